// File: rtl/decripta_rodadas.sv
// decripta_rodadas: AES-128 inverse cipher, one round per clock, valid/ready on both sides.
// Optional macro DECRIPTA_TRAVA_CHAVE_EN latches the key schedule on the accepting edge.

module decripta_coluna (
  input  logic [31:0] col,  // one state column after InvShiftRows
  input  logic [31:0] rk,
  input  logic        mix,
  output logic [31:0] res
);
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // byte x sits at bit offset 8*(255-x); 255-x == ~x for 8-bit x
  function automatic logic [7:0] isb(input logic [7:0] x);
    return INV_SBOX[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] m9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] m11(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] m13(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] m14(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  logic [31:0] ark;
  logic [7:0]  a0, a1, a2, a3;

  always_comb begin
    ark = {isb(col[31:24]), isb(col[23:16]), isb(col[15:8]), isb(col[7:0])} ^ rk;
    {a0, a1, a2, a3} = ark;
    if (mix)
      res = {m14(a0) ^ m11(a1) ^ m13(a2) ^ m9(a3),
             m9(a0)  ^ m14(a1) ^ m11(a2) ^ m13(a3),
             m13(a0) ^ m9(a1)  ^ m14(a2) ^ m11(a3),
             m11(a0) ^ m13(a1) ^ m9(a2)  ^ m14(a3)};
    else
      res = ark;
  end
endmodule

module decripta_rodadas (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          entrada_valida,
  output logic          entrada_pronta,
  input  logic [127:0]  cifrado,
  input  logic [127:0]  chave,
  input  logic [1279:0] chaveExpandida,
  output logic          saida_valida,
  input  logic          saida_pronta,
  output logic [127:0]  texto
);
  typedef enum logic [1:0] {OCIOSO = 2'd0, PROCESSA = 2'd1, CONCLUIDO = 2'd2} estado_t;

  estado_t            estado, prox;
  logic [3:0]         rodada;
  logic [127:0]       st, texto_q, desl, rodada_out, rk;
  logic [127:0]       chave_src;
  logic [1279:0]      exp_src;
  logic [15:0][127:0] rks;
  logic               aceita, ultima;

  assign entrada_pronta = (estado == OCIOSO);
  assign saida_valida   = (estado == CONCLUIDO);
  assign texto          = texto_q;
  assign aceita         = entrada_pronta & entrada_valida;
  assign ultima         = (rodada == 4'd0);

`ifdef DECRIPTA_TRAVA_CHAVE_EN
  logic [127:0]  chave_q;
  logic [1279:0] exp_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chave_q <= '0;
      exp_q   <= '0;
    end else if (aceita) begin
      chave_q <= chave;
      exp_q   <= chaveExpandida;
    end
  end

  assign chave_src = chave_q;
  assign exp_src   = exp_q;
`else
  assign chave_src = chave;
  assign exp_src   = chaveExpandida;
`endif

  // round key table indexed directly by the round counter
  assign rks[0]     = chave_src;
  assign rks[15:11] = '0;
  for (genvar g = 1; g <= 10; g++) begin : g_rk
    assign rks[g] = exp_src[128*(g-1) +: 128];
  end
  assign rk = rks[rodada];

  // InvShiftRows is pure wiring: row r of column c comes from column (c-r) mod 4
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign desl[127-8*(4*c+r) -: 8] = st[127-8*(4*((c-r+4)%4)+r) -: 8];
    end
    decripta_coluna u_col (
      .col (desl[127-32*c -: 32]),
      .rk  (rk[127-32*c -: 32]),
      .mix (~ultima),
      .res (rodada_out[127-32*c -: 32])
    );
  end

  always_comb begin
    prox = estado;
    case (estado)
      OCIOSO:    if (entrada_valida) prox = PROCESSA;
      PROCESSA:  if (ultima)         prox = CONCLUIDO;
      CONCLUIDO: if (saida_pronta)   prox = OCIOSO;
      default:                       prox = OCIOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      estado  <= OCIOSO;
      rodada  <= '0;
      st      <= '0;
      texto_q <= '0;
    end else begin
      estado <= prox;
      case (estado)
        OCIOSO: if (entrada_valida) begin
          st     <= cifrado ^ chaveExpandida[1279:1152];
          rodada <= 4'd9;
        end
        PROCESSA: begin
          if (ultima) texto_q <= rodada_out;
          else begin
            st     <= rodada_out;
            rodada <= rodada - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
